div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 34 +++
 rtl/subtractor_32bit.sv | 11 +
 rtl/div_unit.sv | 141 ++++++++++++++
 tb/tb_div_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: data width, op encoding,
// FSM states and small arithmetic helpers.
package div_unit_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] SIGNED_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return '0 - v;
  endfunction

endpackage

// File: rtl/subtractor_32bit.sv
// 32-bit subtractor; borrow is set when a < b (unsigned).
module subtractor_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic        borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider, fixed 33-cycle latency from accepted start
// to the one-cycle o_valid pulse. Supports DIV, DIVU, REM and REMU.
module div_unit
  import div_unit_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result
);

  div_state_e        state;
  div_op_e           op_q;
  logic [DATA_W-1:0] divisor_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] a_raw_q;
  logic [5:0]        count_q;
  logic              q_neg_q;
  logic              r_neg_q;
  logic              dz_q;
  logic              ovf_q;

  // Accept-side operand conditioning
  div_op_e           op_in;
  logic              signed_in;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic              dz_in;
  logic              ovf_in;

  always_comb begin
    op_in     = div_op_e'(i_op);
    signed_in = op_is_signed(op_in);
    a_mag     = (signed_in && i_a[DATA_W-1]) ? negate(i_a) : i_a;
    b_mag     = (signed_in && i_b[DATA_W-1]) ? negate(i_b) : i_b;
    dz_in     = (i_b == '0);
    ovf_in    = signed_in && (i_a == SIGNED_MIN) && (i_b == '1);
  end

  // One iteration step
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] trial;
  logic              borrow;
  logic              take;
  logic [DATA_W-1:0] rem_nx;
  logic [DATA_W-1:0] quo_nx;

  assign shifted = {rem_q, quo_q[DATA_W-1]};

  subtractor_32bit u_sub (
    .a      (shifted[DATA_W-1:0]),
    .b      (divisor_q),
    .diff   (trial),
    .borrow (borrow)
  );

  // The bit shifted out of rem_q means the partial remainder already exceeds
  // any 32-bit divisor, so the subtraction is taken regardless of borrow.
  always_comb begin
    take   = shifted[DATA_W] | ~borrow;
    rem_nx = take ? trial : shifted[DATA_W-1:0];
    quo_nx = {quo_q[DATA_W-2:0], take};
  end

  // Final fix-up on the last iteration's results
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] res_nx;

  always_comb begin
    quo_fix = q_neg_q ? negate(quo_nx) : quo_nx;
    rem_fix = r_neg_q ? negate(rem_nx) : rem_nx;
    if (dz_q) begin
      quo_fix = '1;
      rem_fix = a_raw_q;
    end
    if (ovf_q) begin
      quo_fix = SIGNED_MIN;
      rem_fix = '0;
    end
    res_nx = op_is_rem(op_q) ? rem_fix : quo_fix;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_DIV;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      a_raw_q   <= '0;
      count_q   <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      o_result  <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            op_q      <= op_in;
            divisor_q <= b_mag;
            rem_q     <= '0;
            quo_q     <= a_mag;
            a_raw_q   <= i_a;
            count_q   <= 6'd31;
            q_neg_q   <= signed_in && (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
            r_neg_q   <= signed_in && i_a[DATA_W-1];
            dz_q      <= dz_in;
            ovf_q     <= ovf_in;
            state     <= ST_CALC;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if (count_q == 6'd0) begin
            o_result <= res_nx;
            state    <= ST_DONE;
          end else begin
            count_q <= count_q - 6'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy  = (state == ST_CALC);
  assign o_valid = (state == ST_DONE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, randomized ops
// against a plain-arithmetic reference, start/reset interaction.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_result (result)
  );

  function automatic logic [31:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                        input logic [31:0] mb);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = ma;
    sb = mb;
    if (mb == 32'd0) return mop[1] ? ma : 32'hFFFF_FFFF;
    if (!mop[0] && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF)
      return mop[1] ? 32'd0 : 32'h8000_0000;
    case (mop)
      2'b00:   return $unsigned(sa / sb);
      2'b01:   return ma / mb;
      2'b10:   return $unsigned(sa % sb);
      default: return ma % mb;
    endcase
  endfunction

  // Counts cycles until o_valid; busy must be high on every cycle before it.
  task automatic wait_valid(input bit scramble, output int lat, output logic [31:0] res,
                            output int busy_bad);
    lat      = 0;
    busy_bad = 0;
    res      = 32'd0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (scramble) begin
        a  = $urandom;
        b  = $urandom;
        op = 2'($urandom);
      end
      if (valid) begin
        res = result;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] top, input logic [31:0] ta,
                        input logic [31:0] tb, input bit scramble);
    int          lat;
    int          bb;
    logic [31:0] res;
    logic [31:0] exp;
    exp   = model(top, ta, tb);
    op    = top;
    a     = ta;
    b     = tb;
    start = 1'b1;
    wait_valid(scramble, lat, res, bb);
    tests++;
    if (res !== exp) begin
      fails++;
      $display("FAIL %s result: got %h expected %h (op=%0d a=%h b=%h)", name, res, exp, top, ta, tb);
    end
    tests++;
    if (lat != 33 || bb != 0) begin
      fails++;
      $display("FAIL %s latency: got %0d busy_gaps %0d expected 33 / 0", name, lat, bb);
    end
    @(negedge clk);
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s pulse: valid=%b busy=%b expected 0/0 after DONE", name, valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b valid=%b result=%h expected 0/0/0", busy, valid, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_by0", 2'b01, 32'd5, 32'd0, 1'b0);
    run_op("rem_by0", 2'b10, 32'd5, 32'd0, 1'b0);
    run_op("div_by0_neg", 2'b00, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_op("rem_by0_neg", 2'b10, 32'h8000_0000, 32'd0, 1'b0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_max", 2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb;
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2, 3:    rb = $urandom_range(1, 300);
        4:       rb = -$urandom_range(1, 300);
        default: rb = $urandom;
      endcase
      run_op("random", 2'($urandom), ra, rb, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    int          bb;
    int          k;
    logic [31:0] res;
    op    = 2'b01;
    a     = 32'd20;
    b     = 32'd3;
    start = 1'b1;
    k     = 0;
    res   = 32'd0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (k == 10) begin
        op    = 2'b01;
        a     = 32'd1000;
        b     = 32'd7;
        start = 1'b1;
      end
      if (valid) begin
        res = result;
        break;
      end
    end
    tests++;
    if (res !== 32'd6 || k != 33) begin
      fails++;
      $display("FAIL ignore_start: result %h at cycle %0d expected 00000006 at 33", res, k);
    end
    // Still in DONE: issue the next request immediately
    op    = 2'b11;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    wait_valid(1'b0, lat, res, bb);
    tests++;
    if (res !== 32'd2 || lat != 33 || bb != 0) begin
      fails++;
      $display("FAIL start_in_done: result %h lat %0d gaps %0d expected 00000002 33 0", res, lat, bb);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    op    = 2'b01;
    a     = 32'd999;
    b     = 32'd4;
    start = 1'b1;
    repeat (15) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b valid=%b result=%h expected 0/0/0", busy, valid, result);
    end
    rst_n = 1'b1;
    seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_mid_abort: activity on %0d cycles expected 0", seen);
    end
  endtask

  task automatic test_reset_start();
    int seen;
    op    = 2'b01;
    a     = 32'd50;
    b     = 32'd5;
    start = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_with_start: activity on %0d cycles expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_reset_start();
    run_op("after_resets", 2'b00, 32'd12345, 32'hFFFF_FFFD, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
